// File: rtl/clk_seq.sv
// clk_seq: clock bring-up/tear-down sequencer driving the clock generator enables and config.
// Walks osc -> source select -> global -> rng/sample -> memory -> core, with settle waits and init-done timeouts.
module clk_seq #(
   parameter int SETTLE_CYCLES = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk_jtag,
   input  logic       rst,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic [1:0] i_cfg_sel_src,
   input  logic [2:0] i_cfg_sys_div,
   input  logic [2:0] i_cfg_smp_div,
   input  logic [5:0] i_cfg_en,
   input  logic       i_clk_initdone,
   input  logic       i_rng_initdone,
   output logic       o_clk_osc_en,
   output logic       o_clk_gbl_en,
   output logic       o_clk_mem_en,
   output logic       o_clk_rng_en,
   output logic       o_clk_smp_en,
   output logic       o_clk_cmo_en,
   output logic       o_clk_dlo_en,
   output logic       o_clk_pln_en,
   output logic [1:0] o_clk_sel_src,
   output logic [2:0] o_clk_sys_div,
   output logic [2:0] o_clk_smp_div,
   output logic       o_seq_busy,
   output logic       o_seq_run,
   output logic       o_seq_err,
   output logic [3:0] o_seq_state
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] S1 = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] S2 = CW'(2 * SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] S3 = CW'(3 * SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] T1 = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      IDLE, OSC, SEL, GBL, RNG, MEM, CORE, RUN, DOWN_CORE, DOWN_GBL, DOWN_OSC, ERR
   } state_t;

   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [1:0] cfg_sel;
   logic [2:0] cfg_sys, cfg_smp;
   logic [5:0] cfg_en;
   logic stp, acc, ent, keep_osc, keep_gbl, keep_dom, core_tick;

   assign o_seq_state = state;

   always_comb begin
      stp = i_stop && state != IDLE && state != ERR;
      acc = (state == IDLE || state == ERR) && i_start && !i_stop;
      nxt = state;
      if (acc) nxt = OSC;
      else if (stp) nxt = DOWN_CORE;
      else if (state == ERR && i_stop) nxt = IDLE;
      else
         case (state)
            OSC:       nxt = cnt == S1 ? SEL : OSC;
            SEL:       nxt = cnt == S1 ? GBL : SEL;
            GBL:       nxt = i_clk_initdone ? RNG : (cnt == T1 ? ERR : GBL);
            RNG:       nxt = (!cfg_en[1] || i_rng_initdone) ? MEM : (cnt == T1 ? ERR : RNG);
            MEM:       nxt = cnt == S1 ? CORE : MEM;
            CORE:      nxt = cnt == S3 ? RUN : CORE;
            DOWN_CORE: nxt = cnt == S1 ? DOWN_GBL : DOWN_CORE;
            DOWN_GBL:  nxt = cnt == S1 ? DOWN_OSC : DOWN_GBL;
            DOWN_OSC:  nxt = cnt == S1 ? IDLE : DOWN_OSC;
            default:   ;
         endcase
      // a stop during teardown restarts it, so entry is not just a state change
      ent = stp || nxt != state;
      keep_osc = nxt inside {OSC, SEL, GBL, RNG, MEM, CORE, RUN, DOWN_CORE, DOWN_GBL};
      keep_gbl = nxt inside {GBL, RNG, MEM, CORE, RUN, DOWN_CORE};
      keep_dom = nxt inside {RNG, MEM, CORE, RUN};
      core_tick = state == CORE && nxt == CORE;
   end

   always_ff @(posedge clk_jtag) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         cfg_sel <= '0;
         cfg_sys <= '0;
         cfg_smp <= '0;
         cfg_en <= '0;
         o_clk_osc_en <= 1'b0;
         o_clk_gbl_en <= 1'b0;
         o_clk_mem_en <= 1'b0;
         o_clk_rng_en <= 1'b0;
         o_clk_smp_en <= 1'b0;
         o_clk_cmo_en <= 1'b0;
         o_clk_dlo_en <= 1'b0;
         o_clk_pln_en <= 1'b0;
         o_clk_sel_src <= '0;
         o_clk_sys_div <= '0;
         o_clk_smp_div <= '0;
         o_seq_busy <= 1'b0;
         o_seq_run <= 1'b0;
         o_seq_err <= 1'b0;
      end else begin
         state <= nxt;
         cnt <= ent ? '0 : cnt + CW'(cnt != TMAX);
         if (acc) begin
            cfg_sel <= i_cfg_sel_src;
            cfg_sys <= i_cfg_sys_div;
            cfg_smp <= i_cfg_smp_div;
            cfg_en <= i_cfg_en;
         end
         o_clk_osc_en <= nxt == OSC || (o_clk_osc_en && keep_osc);
         o_clk_gbl_en <= nxt == GBL || (o_clk_gbl_en && keep_gbl);
         o_clk_rng_en <= nxt == RNG ? cfg_en[1] : o_clk_rng_en && keep_dom;
         o_clk_smp_en <= nxt == RNG ? cfg_en[2] : o_clk_smp_en && keep_dom;
         o_clk_mem_en <= nxt == MEM ? cfg_en[0] : o_clk_mem_en && keep_dom;
         o_clk_cmo_en <= nxt == CORE ? cfg_en[3] : o_clk_cmo_en && keep_dom;
         o_clk_dlo_en <= core_tick && cnt == S1 ? cfg_en[4] : o_clk_dlo_en && keep_dom;
         o_clk_pln_en <= core_tick && cnt == S2 ? cfg_en[5] : o_clk_pln_en && keep_dom;
         o_clk_sel_src <= nxt == SEL ? cfg_sel : (keep_osc ? o_clk_sel_src : '0);
         o_clk_sys_div <= nxt == SEL ? cfg_sys : (keep_osc ? o_clk_sys_div : '0);
         o_clk_smp_div <= nxt == SEL ? cfg_smp : (keep_osc ? o_clk_smp_div : '0);
         o_seq_busy <= !(nxt inside {IDLE, RUN, ERR});
         o_seq_run <= nxt == RUN;
         o_seq_err <= nxt == ERR || (o_seq_err && !acc);
      end
   end
endmodule

// File: tb/tb_clk_seq.sv
// tb_clk_seq: randomized and directed checks of clk_seq against a phase/event reference model.
module tb_clk_seq;
   localparam int SET = 4;
   localparam int TO = 32;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, stop = 1'b0, cid = 1'b0, rid = 1'b0;
   logic [1:0] cfg_sel = '0;
   logic [2:0] cfg_sys = '0, cfg_smp = '0;
   logic [5:0] cfg_en = '0;
   logic osc, gbl, mem, rng, smp, cmo, dlo, pln, busy, run, err;
   logic [1:0] sel;
   logic [2:0] sys, sdiv;
   logic [3:0] st;
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   clk_seq #(.SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
      .clk_jtag(clk), .rst(rst), .i_start(start), .i_stop(stop),
      .i_cfg_sel_src(cfg_sel), .i_cfg_sys_div(cfg_sys), .i_cfg_smp_div(cfg_smp), .i_cfg_en(cfg_en),
      .i_clk_initdone(cid), .i_rng_initdone(rid),
      .o_clk_osc_en(osc), .o_clk_gbl_en(gbl), .o_clk_mem_en(mem), .o_clk_rng_en(rng),
      .o_clk_smp_en(smp), .o_clk_cmo_en(cmo), .o_clk_dlo_en(dlo), .o_clk_pln_en(pln),
      .o_clk_sel_src(sel), .o_clk_sys_div(sys), .o_clk_smp_div(sdiv),
      .o_seq_busy(busy), .o_seq_run(run), .o_seq_err(err), .o_seq_state(st)
   );

   // phases: 0 idle,1 osc,2 sel,3 gbl,4 rng,5 mem,6 core,7 run,8 down_core,9 down_gbl,10 down_osc,11 err
   int ph = 0, age = 0, nph, el;
   bit ment;
   logic m_osc, m_gbl, m_mem, m_rng, m_smp, m_cmo, m_dlo, m_pln, m_err;
   logic [1:0] m_sel, l_sel;
   logic [2:0] m_sys, m_sdiv, l_sys, l_smp;
   logic [5:0] l_en;

   always @(posedge clk) begin
      if (rst) begin
         ph = 0; age = 0;
         {m_osc, m_gbl, m_mem, m_rng, m_smp, m_cmo, m_dlo, m_pln, m_err} = '0;
         {m_sel, m_sys, m_sdiv, l_sel, l_sys, l_smp, l_en} = '0;
      end else begin
         el = age + 1;
         nph = ph;
         ment = 0;
         if ((ph == 0 || ph == 11) && start && !stop) begin
            nph = 1; m_err = 0;
            l_sel = cfg_sel; l_sys = cfg_sys; l_smp = cfg_smp; l_en = cfg_en;
         end else if (ph == 11 && stop) nph = 0;
         else if (ph != 0 && ph != 11 && stop) begin nph = 8; ment = 1; end
         else
            case (ph)
               1: if (el == SET) nph = 2;
               2: if (el == SET) nph = 3;
               3: if (cid) nph = 4; else if (el == TO) nph = 11;
               4: if (!l_en[1] || rid) nph = 5; else if (el == TO) nph = 11;
               5: if (el == SET) nph = 6;
               6: begin
                  if (el == 3 * SET) nph = 7;
                  if (el == SET) m_dlo = l_en[4];
                  if (el == 2 * SET) m_pln = l_en[5];
               end
               8: if (el == SET) nph = 9;
               9: if (el == SET) nph = 10;
               10: if (el == SET) nph = 0;
               default: ;
            endcase
         if (nph != ph) ment = 1;
         if (ment)
            case (nph)
               1: m_osc = 1;
               2: begin m_sel = l_sel; m_sys = l_sys; m_sdiv = l_smp; end
               3: m_gbl = 1;
               4: begin m_rng = l_en[1]; m_smp = l_en[2]; end
               5: m_mem = l_en[0];
               6: m_cmo = l_en[3];
               8: {m_rng, m_smp, m_mem, m_cmo, m_dlo, m_pln} = '0;
               9: m_gbl = 0;
               10: begin m_osc = 0; m_sel = 0; m_sys = 0; m_sdiv = 0; end
               11: begin
                  {m_osc, m_gbl, m_mem, m_rng, m_smp, m_cmo, m_dlo, m_pln} = '0;
                  m_sel = 0; m_sys = 0; m_sdiv = 0; m_err = 1;
               end
               default: ;
            endcase
         age = ment ? 0 : age + 1;
         ph = nph;
      end
   end

   function automatic logic [19:0] obs();
      return {osc, gbl, mem, rng, smp, cmo, dlo, pln, sel, sys, sdiv, busy, run, err, st == 4'd0};
   endfunction

   function automatic logic [19:0] expv();
      return {m_osc, m_gbl, m_mem, m_rng, m_smp, m_cmo, m_dlo, m_pln, m_sel, m_sys, m_sdiv,
              !(ph inside {0, 7, 11}), ph == 7, m_err, ph == 0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input bit s, input bit p, input bit r);
      start = s; stop = p; rst = r;
      @(posedge clk);
      @(negedge clk);
      start = 0; stop = 0; rst = 0;
      chk("cyc", obs(), expv());
   endtask

   task automatic teardown();
      cyc(0, 1, 0);
      repeat (13) cyc(0, 0, 0);
   endtask

   initial begin
      int n;
      bit [1:0] mode;
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("reset", obs(), 20'h1);
      chk("reset_state", st, 0);

      // nominal bring-up
      cfg_en = 6'b111111; cfg_sel = 2; cfg_sys = 3; cfg_smp = 5; cid = 1; rid = 1;
      cyc(1, 0, 0);
      chk("osc_k1", osc, 1);
      for (int k = 2; k <= 27; k++) begin
         cyc(0, 0, 0);
         if (k == 4) chk("sel_k4", sel, 0);
         if (k == 5) chk("sel_k5", {sel, sys, sdiv}, {2'd2, 3'd3, 3'd5});
         if (k == 8) chk("gbl_k8", gbl, 0);
         if (k == 9) chk("gbl_k9", gbl, 1);
         if (k == 10) chk("rng_k10", {rng, smp}, 2'b11);
         if (k == 11) chk("mem_k11", mem, 1);
         if (k == 15) chk("cmo_k15", cmo, 1);
         if (k == 18) chk("dlo_k18", dlo, 0);
         if (k == 19) chk("dlo_k19", dlo, 1);
         if (k == 23) chk("pln_k23", pln, 1);
         if (k == 26) chk("run_k26", run, 0);
      end
      chk("run_k27", {run, busy}, 2'b10);

      // start while running is ignored
      cfg_sel = 1; cfg_en = 0;
      cyc(1, 0, 0);
      chk("start_in_run", {run, sel, pln}, {1'b1, 2'd2, 1'b1});

      // stop from run
      cyc(0, 1, 0);
      chk("stop_dom", {rng, smp, mem, cmo, dlo, pln, gbl, busy}, 8'b00000011);
      for (int j = 2; j <= 13; j++) begin
         cyc(0, 0, 0);
         if (j == 4) chk("stop_gbl_j4", gbl, 1);
         if (j == 5) chk("stop_gbl_j5", gbl, 0);
         if (j == 9) chk("stop_osc_j9", osc, 0);
         if (j == 12) chk("stop_busy_j12", {busy, sel}, 3'b100);
      end
      chk("stop_idle", {st, busy}, 5'd0);

      // timeout on clock init-done
      cid = 0; cfg_en = 6'b111111;
      cyc(1, 0, 0);
      for (int k = 2; k <= 41; k++) begin
         cyc(0, 0, 0);
         if (k == 40) chk("to_k40", {err, gbl}, 2'b01);
      end
      chk("to_k41", {err, osc, gbl, sel}, 5'b10000);
      cid = 1;
      cyc(1, 0, 0);
      chk("err_restart", {err, osc}, 2'b01);
      teardown();

      // memory-only configuration
      cfg_en = 6'b000001; rid = 0;
      cyc(1, 0, 0);
      for (int k = 2; k <= 27; k++) begin
         cyc(0, 0, 0);
         if (k == 11) chk("part_mem", {mem, rng, smp}, 3'b100);
         if (k == 26) chk("part_run26", run, 0);
      end
      chk("part_run27", {run, cmo, dlo, pln}, 4'b1000);
      teardown();

      // stop while waiting for init-done
      cid = 0; rid = 1;
      cyc(1, 0, 0);
      repeat (11) cyc(0, 0, 0);
      cyc(0, 1, 0);
      chk("abort_gbl", {osc, gbl, busy}, 3'b111);
      for (int j = 2; j <= 13; j++) begin
         cyc(0, 0, 0);
         if (j == 5) chk("abort_gbl_j5", {osc, gbl}, 2'b10);
         if (j == 9) chk("abort_osc_j9", osc, 0);
      end
      chk("abort_idle", st, 0);

      cyc(1, 1, 0);
      chk("ss_idle", {st, busy, osc}, 6'd0);

      // reset in the middle of the core stagger
      cid = 1; cfg_en = 6'b111111; cfg_sel = 3;
      cyc(1, 0, 0);
      repeat (15) cyc(0, 0, 0);
      chk("pre_rst_core", cmo, 1);
      cyc(0, 0, 1);
      chk("rst_core", obs(), 20'h1);
      cyc(0, 0, 0);
      chk("rst_cfg", sel, 0);

      for (int e = 0; e < 40; e++) begin
         cfg_en = 6'($urandom); cfg_sel = 2'($urandom); cfg_sys = 3'($urandom); cfg_smp = 3'($urandom);
         mode = 2'($urandom_range(0, 2));
         cyc(1, $urandom_range(0, 9) == 0, 0);
         n = $urandom_range(20, 120);
         for (int c = 0; c < n; c++) begin
            cid = mode == 0 ? 1'b1 : mode == 1 ? $urandom_range(0, 5) == 0 : 1'b0;
            rid = mode == 2 ? 1'b0 : $urandom_range(0, 3) == 0;
            cfg_en = 6'($urandom); cfg_sel = 2'($urandom);
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
         end
         teardown();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
